// File: rtl/bcd_timer_chain_if.sv
// Control and status bundle for the cascaded BCD timer.
// The controller (master) drives load/tick/direction; the timer (slave) returns the count and its flags.
interface bcd_timer_chain_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    loadn;
    logic [4*NUM_DIGITS-1:0] data;
    logic                    tick;
    logic                    run;
    logic                    up;
    logic [4*NUM_DIGITS-1:0] count;
    logic                    zero;
    logic                    tc;
    logic                    done;

    modport master (
        output loadn,
        output data,
        output tick,
        output run,
        output up,
        input  count,
        input  zero,
        input  tc,
        input  done
    );

    modport slave (
        input  loadn,
        input  data,
        input  tick,
        input  run,
        input  up,
        output count,
        output zero,
        output tc,
        output done
    );
endinterface

// File: rtl/bcd_timer_chain.sv
// Cascaded multi-digit BCD up/down timer with per-digit modulus, sanitised load,
// optional auto-stop at zero, and registered wrap (tc) / arrival-at-zero (done) pulses.
module bcd_timer_chain #(
    parameter int          NUM_DIGITS = 4,
    parameter logic [31:0] DIGIT_MODS = 32'h0000_6A6A,
    parameter bit          AUTO_STOP  = 1'b1
) (
    input  logic                clk,
    input  logic                clrn,
    bcd_timer_chain_if.slave    bus
);

    localparam int W = 4 * NUM_DIGITS;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         tc_q;
    logic         tc_d;
    logic         done_q;
    logic         done_d;

    logic [W-1:0] sanitised_s;
    logic [W-1:0] stepped_s;
    logic         wrap_s;
    logic         zero_s;

    function automatic logic [3:0] mod_of(input int idx);
        mod_of = DIGIT_MODS[4*idx +: 4];
    endfunction

    // A digit at or above its modulus collapses to the largest legal value.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] m);
        if (d >= m) begin
            clamp_digit = m - 4'd1;
        end else begin
            clamp_digit = d;
        end
    endfunction

    function automatic logic is_terminal(input logic [3:0] d, input logic [3:0] m,
                                         input logic dir_up);
        if (dir_up) begin
            is_terminal = (d == (m - 4'd1));
        end else begin
            is_terminal = (d == 4'd0);
        end
    endfunction

    function automatic logic [3:0] step_digit(input logic [3:0] d, input logic [3:0] m,
                                              input logic dir_up);
        if (dir_up) begin
            if (d == (m - 4'd1)) begin
                step_digit = 4'd0;
            end else begin
                step_digit = d + 4'd1;
            end
        end else begin
            if (d == 4'd0) begin
                step_digit = m - 4'd1;
            end else begin
                step_digit = d - 4'd1;
            end
        end
    endfunction

    assign zero_s = (count_q == {W{1'b0}});

    // Load value with every digit forced into its legal range.
    always_comb begin
        sanitised_s = {W{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sanitised_s[4*i +: 4] = clamp_digit(bus.data[4*i +: 4], mod_of(i));
        end
    end

    // Ripple the enable through the chain: a digit steps only when all lower digits are terminal.
    always_comb begin : chain_step
        logic carry_v;
        carry_v   = 1'b1;
        stepped_s = count_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry_v) begin
                stepped_s[4*i +: 4] = step_digit(count_q[4*i +: 4], mod_of(i), bus.up);
            end else begin
                stepped_s[4*i +: 4] = count_q[4*i +: 4];
            end
            carry_v = carry_v & is_terminal(count_q[4*i +: 4], mod_of(i), bus.up);
        end
        wrap_s = carry_v;
    end

    // Next-state selection: load beats tick, and a down tick at zero is swallowed when auto-stop is on.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        done_d  = 1'b0;
        if (!bus.loadn) begin
            count_d = sanitised_s;
        end else if (bus.tick && bus.run) begin
            if (AUTO_STOP && !bus.up && zero_s) begin
                count_d = count_q;
            end else begin
                count_d = stepped_s;
                tc_d    = wrap_s;
                done_d  = !bus.up && !zero_s && (stepped_s == {W{1'b0}});
            end
        end else begin
            count_d = count_q;
        end
    end

    // State and pulse registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count_q <= {W{1'b0}};
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.zero  = zero_s;
    assign bus.tc    = tc_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_bcd_timer_chain.sv
// Bench for bcd_timer_chain: an MM:SS instance with auto-stop and one that wraps at zero,
// both compared every cycle against a mixed-radix integer model, plus directed literal checks.
module tb_bcd_timer_chain;

    localparam int ND = 4;
    localparam int M  = 3600;

    logic        clk = 1'b0;
    logic        clrn;
    logic        loadn;
    logic [15:0] data;
    logic        tick;
    logic        run;
    logic        up;

    int checks = 0;
    int errors = 0;
    int mods [4] = '{10, 6, 10, 6};

    int mv_a = 0;
    int mv_b = 0;
    bit mtc_a = 1'b0;
    bit mtc_b = 1'b0;
    bit mdone_a = 1'b0;
    bit mdone_b = 1'b0;

    bcd_timer_chain_if #(.NUM_DIGITS(ND)) if_a ();
    bcd_timer_chain_if #(.NUM_DIGITS(ND)) if_b ();

    assign if_a.loadn = loadn;
    assign if_a.data  = data;
    assign if_a.tick  = tick;
    assign if_a.run   = run;
    assign if_a.up    = up;
    assign if_b.loadn = loadn;
    assign if_b.data  = data;
    assign if_b.tick  = tick;
    assign if_b.run   = run;
    assign if_b.up    = up;

    bcd_timer_chain #(.NUM_DIGITS(ND), .DIGIT_MODS(32'h0000_6A6A), .AUTO_STOP(1'b1)) dut_a (
        .clk   (clk),
        .clrn  (clrn),
        .bus   (if_a.slave)
    );

    bcd_timer_chain #(.NUM_DIGITS(ND), .DIGIT_MODS(32'h0000_6A6A), .AUTO_STOP(1'b0)) dut_b (
        .clk   (clk),
        .clrn  (clrn),
        .bus   (if_b.slave)
    );

    always #5 clk = ~clk;

    // Packed BCD (sanitised per digit) to a plain integer in the mixed radix 6,10,6,10.
    function automatic int to_val(input logic [15:0] p);
        int v = 0;
        int w = 1;
        int d;
        for (int i = 0; i < ND; i++) begin
            d = int'(p[4*i +: 4]);
            if (d >= mods[i]) d = mods[i] - 1;
            v = v + d * w;
            w = w * mods[i];
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = 16'h0000;
        int rem = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(rem % mods[i]);
            rem = rem / mods[i];
        end
        return r;
    endfunction

    function automatic int next_val(input int v, input bit stop);
        if (!loadn) return to_val(data);
        if (tick && run) begin
            if (up) return (v + 1) % M;
            if (v == 0) return stop ? 0 : M - 1;
            return v - 1;
        end
        return v;
    endfunction

    function automatic bit next_tc(input int v, input bit stop);
        if (!loadn) return 1'b0;
        if (tick && run) begin
            if (up) return (v == M - 1);
            return (v == 0) && !stop;
        end
        return 1'b0;
    endfunction

    function automatic bit next_done(input int v);
        if (!loadn) return 1'b0;
        return tick && run && !up && (v == 1);
    endfunction

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mv_a <= 0; mtc_a <= 1'b0; mdone_a <= 1'b0;
            mv_b <= 0; mtc_b <= 1'b0; mdone_b <= 1'b0;
        end else begin
            mv_a    <= next_val(mv_a, 1'b1);
            mtc_a   <= next_tc(mv_a, 1'b1);
            mdone_a <= next_done(mv_a);
            mv_b    <= next_val(mv_b, 1'b0);
            mtc_b   <= next_tc(mv_b, 1'b0);
            mdone_b <= next_done(mv_b);
        end
    end

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk16("model a.count", if_a.count, to_bcd(mv_a));
        chk1("model a.zero", if_a.zero, mv_a == 0);
        chk1("model a.tc", if_a.tc, mtc_a);
        chk1("model a.done", if_a.done, mdone_a);
        chk16("model b.count", if_b.count, to_bcd(mv_b));
        chk1("model b.zero", if_b.zero, mv_b == 0);
        chk1("model b.tc", if_b.tc, mtc_b);
        chk1("model b.done", if_b.done, mdone_b);
    end

    task automatic step(input logic l, input logic [15:0] d, input logic t,
                        input logic r, input logic u);
        loadn = l;
        data  = d;
        tick  = t;
        run   = r;
        up    = u;
        @(posedge clk);
        #1;
    endtask

    int  nd;
    logic cur_up;

    initial begin
        clrn = 1'b0; loadn = 1'b1; data = 16'h0000; tick = 1'b0; run = 1'b0; up = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk16("reset count", if_a.count, 16'h0000);
        chk1("reset zero", if_a.zero, 1'b1);
        chk1("reset tc", if_a.tc, 1'b0);
        chk1("reset done", if_a.done, 1'b0);
        clrn = 1'b1;

        // Reset mid-count
        step(1'b0, 16'h1234, 1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1);
        chk16("up 3 ticks", if_a.count, 16'h1237);
        #1 clrn = 1'b0;
        #1;
        chk16("async clear count", if_a.count, 16'h0000);
        chk1("async clear zero", if_a.zero, 1'b1);
        chk1("async clear tc", if_a.tc, 1'b0);
        chk1("async clear done", if_a.done, 1'b0);
        clrn = 1'b1;

        // Down cascade and auto-stop
        step(1'b0, 16'h0100, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        chk16("down borrow", if_a.count, 16'h0059);
        nd = 0;
        repeat (59) begin
            step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
            if (if_a.done) nd++;
        end
        chk16("down to zero", if_a.count, 16'h0000);
        chk16("done pulses", 16'(nd), 16'd1);
        chk1("zero at end", if_a.zero, 1'b1);
        step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        chk16("auto-stop hold", if_a.count, 16'h0000);
        chk1("auto-stop tc", if_a.tc, 1'b0);
        chk1("auto-stop done", if_a.done, 1'b0);

        // Up wrap
        step(1'b0, 16'h5958, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1);
        chk16("up to max", if_a.count, 16'h5959);
        chk1("no tc before wrap", if_a.tc, 1'b0);
        step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1);
        chk16("up wrap", if_a.count, 16'h0000);
        chk1("up wrap tc", if_a.tc, 1'b1);
        chk1("up wrap done", if_a.done, 1'b0);
        step(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk1("tc one cycle", if_a.tc, 1'b0);

        // Sanitised load beats a simultaneous tick
        step(1'b0, 16'h9A7F, 1'b1, 1'b1, 1'b1);
        chk16("sanitised load", if_a.count, 16'h5959);
        chk1("load tc", if_a.tc, 1'b0);

        // Pause then run down
        step(1'b0, 16'h0010, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk16("paused", if_a.count, 16'h0010);
        nd = 0;
        repeat (10) begin
            step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
            if (if_a.done) nd++;
        end
        chk16("run to zero", if_a.count, 16'h0000);
        chk16("run done pulses", 16'(nd), 16'd1);

        // Non-stopping instance wraps down at zero
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        chk16("b down wrap", if_b.count, 16'h5959);
        chk1("b down wrap tc", if_b.tc, 1'b1);
        chk1("b down wrap done", if_b.done, 1'b0);
        chk16("a holds at zero", if_a.count, 16'h0000);

        // Randomised traffic checked by the model on every negedge
        cur_up = 1'b0;
        repeat (3000) begin
            logic [15:0] d;
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 0) d[15:8] = 8'h00;
            if ($urandom_range(0, 47) == 0) cur_up = ~cur_up;
            step(($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1, d,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), cur_up);
            if ($urandom_range(0, 199) == 0) begin
                #1 clrn = 1'b0;
                #1 clrn = 1'b1;
            end
        end

        step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_timer_chain.md
Name: bcd_timer_chain

Overview:
Parametrised multi-digit BCD timer counter. It generalises the single fixed-modulus digit into a cascaded chain of NUM_DIGITS digits, each with its own modulus. It counts up or down and has synchronous load with input sanitising, auto-stop at zero, and terminal/done pulses. It sits in the timer path and is driven by the 1 Hz tick; the default configuration is MM:SS for the microwave display.

Parameters:
NUM_DIGITS, 4, number of cascaded BCD digits (1..8); digit 0 is least significant.
DIGIT_MODS, 32'h0000_6A6A, packed 4-bit modulus per digit; nibble i is the modulus of digit i; legal range 2..10. The default gives sec units mod 10, sec tens mod 6, min units mod 10, min tens mod 6.
AUTO_STOP, 1, when 1 a down-count holds at all-zero; when 0 it wraps to the all-max value.

Ports:
clk  in  1  system clock, rising edge.
clrn  in  1  asynchronous active-low reset/clear.
loadn  in  1  synchronous active-low load strobe.
data  in  4*NUM_DIGITS  load value, packed BCD, digit 0 in [3:0].
tick  in  1  count-enable strobe, one clk wide.
run  in  1  1 means ticks are honoured; 0 means paused.
up  in  1  1 counts up, 0 counts down.
count  out  4*NUM_DIGITS  current packed BCD value (registered).
zero  out  1  high while every digit is 0.
tc  out  1  one-cycle pulse on full-chain wrap.
done  out  1  one-cycle pulse when a down-count arrives at zero.

Behaviour:
- Reset (clrn=0, asynchronous, highest priority):
  - count=0, tc=0, done=0, zero=1.
  - Reset is honoured mid-count; the counter resumes from 0 after release.
- Per-cycle priority: clrn > loadn > (tick & run) > hold.
- Load (loadn=0 at the clk edge):
  - count <= data on the next edge.
  - Each digit is sanitised: a digit >= its modulus loads as modulus-1 (e.g. 9 into a mod-6 digit loads 5).
  - A load overrides any simultaneous tick; tc and done stay 0 that cycle.
- Step (tick=1, run=1, loadn=1):
  - Digit i steps iff every lower digit is at its terminal value before the step.
  - Terminal value is 0 when counting down and modulus-1 when counting up.
  - Down: a digit at 0 steps to modulus-1, otherwise to value-1.
  - Up: a digit at modulus-1 steps to 0, otherwise to value+1.
  - The whole chain updates in a single edge; latency from tick to new count is 1 clk.
- Pause: with run=0 or tick=0, count holds. The up input may change at any time and takes effect on the next step.
- zero is combinational from the count register (no added latency).
- tc:
  - Registered; high for exactly one cycle after a step in which every digit was terminal (full wrap).
  - Down wrap example: 00:00 -> 59:59. Up wrap example: 59:59 -> 00:00.
- done:
  - Registered; high for one cycle after a down step that takes count from nonzero to all-zero.
  - Never asserted in up mode.
- AUTO_STOP=1 and down mode:
  - A tick while zero=1 is ignored: count holds, tc=0, done=0.
  - The stop is released by a load, by switching to up, or by reset.
- AUTO_STOP=0 and down mode: a tick at zero wraps and pulses tc, with no done pulse.
- Out-of-range digits never appear: load sanitising plus modulus wrap keep every digit < its modulus at all times.
- tc and done are never high in the same cycle.

Test Plan:
- Reset mid-count: load 12:34, apply 3 ticks, pulse clrn low between edges -> count=00:00 immediately, zero=1, tc=0, done=0.
- Down cascade: load 01:00, run=1, up=0, one tick -> 00:59 after 1 clk. Continue 59 more ticks -> 00:00, done pulses exactly once, zero=1. A further tick -> count holds 00:00, no tc (AUTO_STOP=1).
- Up wrap: load 59:58, up=1, 2 ticks -> 59:59 then 00:00, tc high for one cycle after the second tick, done stays 0.
- Load sanitise and priority: data=9A:7F packed (digits 9,10,7,15) with loadn=0 and tick=1 in the same cycle -> count=59:59, digits unchanged by the tick, tc=0.
- Pause: load 00:10, run=0, 5 ticks -> count stays 00:10. Set run=1, apply 10 ticks -> 00:00, done pulses once.
- AUTO_STOP=0 instance: load 00:00, up=0, one tick -> 59:59, tc pulses, done=0.
